// File: rtl/answer_checker.sv
// -----------------------------------------------------------------------------
// answer_checker
//
// Poses an arithmetic problem (operand1 <op> operand2), computes the expected
// answer, then accepts a decimal keypad entry and grades it. Three attempts are
// allowed per problem; a correct answer disarms the checker, three wrong answers
// lock it out until the next problem is started.
//
// Ports
//   clk            system clock, all state changes on its rising edge
//   rst            synchronous active-high reset
//   start          one-cycle pulse, latches operand1/operand2/operation
//   operand1       first operand, unsigned 8 bit
//   operand2       second operand, unsigned 8 bit
//   operation      000 +, 001 -, 010 *, 011 /, 100 %, others give 0
//   digit_valid    keypad digit strobe
//   digit          keypad digit, BCD 0-9 (values above 9 are ignored)
//   enter          submit the current entry
//   clear          erase the current entry
//   busy           high while the expected answer is being computed
//   expected       computed answer
//   entry          accumulated decimal entry as a binary value
//   correct        one-cycle pulse, entry matched
//   wrong          one-cycle pulse, entry did not match
//   attempts_left  remaining attempts
//   disarmed       level, problem solved
//   lockout        level, attempts exhausted
// -----------------------------------------------------------------------------
module answer_checker (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] operand1,
    input  logic [7:0] operand2,
    input  logic [2:0] operation,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       enter,
    input  logic       clear,
    output logic       busy,
    output logic [7:0] expected,
    output logic [9:0] entry,
    output logic       correct,
    output logic       wrong,
    output logic [1:0] attempts_left,
    output logic       disarmed,
    output logic       lockout
);

    typedef enum logic [2:0] {IDLE, CALC, ENTRY, DONE, LOCK} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;

    state_t     state, state_next;

    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [2:0] op_code;
    logic [1:0] digit_cnt;

    // Restoring divider: div_quo starts as the dividend and shifts quotient
    // bits in from the right while dividend bits leave from the left.
    logic [2:0] div_cnt;
    logic [7:0] div_rem;
    logic [7:0] div_quo;

    logic        long_div;
    logic        calc_done;
    logic [8:0]  div_shifted;
    logic [9:0]  div_diff;
    logic        div_borrow;
    logic [7:0]  rem_next;
    logic [7:0]  quo_next;
    logic [15:0] product;
    logic [7:0]  quick_result;
    logic        digit_ok;
    logic        has_entry;
    logic        match;

    assign long_div    = ((op_code == OP_DIV) || (op_code == OP_MOD)) && (op_b != 8'd0);
    assign calc_done   = (state == CALC) && (!long_div || (div_cnt == 3'd7));

    assign div_shifted = {div_rem, div_quo[7]};
    assign div_diff    = {1'b0, div_shifted} - {2'b00, op_b};
    assign div_borrow  = div_diff[9];
    // Either branch fits in 8 bits because the remainder is always below op_b.
    assign rem_next    = div_borrow ? div_shifted[7:0] : div_diff[7:0];
    assign quo_next    = {div_quo[6:0], ~div_borrow};

    assign product     = {8'd0, op_a} * {8'd0, op_b};

    // Single-cycle results; division by zero and invalid codes fall to 0.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // it unassigned, which would infer a latch.
        quick_result = 8'd0;
        case (op_code)
            OP_ADD:  quick_result = op_a + op_b;
            OP_SUB:  quick_result = op_a - op_b;
            OP_MUL:  quick_result = product[7:0];
            default: quick_result = 8'd0;
        endcase
    end

    assign digit_ok  = digit_valid && (digit <= 4'd9) && (digit_cnt < 2'd3);
    assign has_entry = (digit_cnt != 2'd0);
    assign match     = (entry == {2'b00, expected});
    assign busy      = (state == CALC);

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so all
        // registers update together from values sampled before the edge.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start overrides everything except rst.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = CALC;
        end else begin
            case (state)
                CALC: begin
                    if (calc_done) begin
                        state_next = ENTRY;
                    end
                end
                ENTRY: begin
                    if (enter && has_entry) begin
                        if (match) begin
                            state_next = DONE;
                        end else if (attempts_left == 2'd1) begin
                            state_next = LOCK;
                        end
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_a          <= 8'd0;
            op_b          <= 8'd0;
            op_code       <= 3'd0;
            div_cnt       <= 3'd0;
            div_rem       <= 8'd0;
            div_quo       <= 8'd0;
            expected      <= 8'd0;
            entry         <= 10'd0;
            digit_cnt     <= 2'd0;
            correct       <= 1'b0;
            wrong         <= 1'b0;
            attempts_left <= 2'd0;
            disarmed      <= 1'b0;
            lockout       <= 1'b0;
        end else begin
            correct <= 1'b0;
            wrong   <= 1'b0;
            if (start) begin
                op_a          <= operand1;
                op_b          <= operand2;
                op_code       <= operation;
                div_cnt       <= 3'd0;
                div_rem       <= 8'd0;
                div_quo       <= operand1;
                entry         <= 10'd0;
                digit_cnt     <= 2'd0;
                attempts_left <= 2'd3;
                disarmed      <= 1'b0;
                lockout       <= 1'b0;
            end else begin
                case (state)
                    CALC: begin
                        if (long_div) begin
                            div_rem <= rem_next;
                            div_quo <= quo_next;
                            div_cnt <= div_cnt + 3'd1;
                            if (div_cnt == 3'd7) begin
                                expected <= (op_code == OP_DIV) ? quo_next : rem_next;
                            end
                        end else begin
                            expected <= quick_result;
                        end
                    end
                    ENTRY: begin
                        // enter wins over clear and digit; an empty entry is not graded.
                        if (enter) begin
                            if (has_entry) begin
                                if (match) begin
                                    correct  <= 1'b1;
                                    disarmed <= 1'b1;
                                end else begin
                                    wrong         <= 1'b1;
                                    attempts_left <= attempts_left - 2'd1;
                                    entry         <= 10'd0;
                                    digit_cnt     <= 2'd0;
                                    if (attempts_left == 2'd1) begin
                                        lockout <= 1'b1;
                                    end
                                end
                            end
                        end else if (clear) begin
                            entry     <= 10'd0;
                            digit_cnt <= 2'd0;
                        end else if (digit_ok) begin
                            entry     <= entry * 10'd10 + {6'd0, digit};
                            digit_cnt <= digit_cnt + 2'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_answer_checker.sv
// -----------------------------------------------------------------------------
// tb_answer_checker
//
// Self-checking bench for answer_checker. Every problem started pushes its
// reference answer and computation latency onto a queue; when busy drops the
// entry is popped and compared with the DUT. Keypad scenarios compare pulses,
// attempts and entry against constants worked out from the problem.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_answer_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] operand1;
    logic [7:0] operand2;
    logic [2:0] operation;
    logic       digit_valid;
    logic [3:0] digit;
    logic       enter;
    logic       clear;
    logic       busy;
    logic [7:0] expected;
    logic [9:0] entry;
    logic       correct;
    logic       wrong;
    logic [1:0] attempts_left;
    logic       disarmed;
    logic       lockout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] ans;
        int         lat;
        int         a;
        int         b;
        int         op;
    } calc_t;

    calc_t exp_q[$];

    answer_checker dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .operand1      (operand1),
        .operand2      (operand2),
        .operation     (operation),
        .digit_valid   (digit_valid),
        .digit         (digit),
        .enter         (enter),
        .clear         (clear),
        .busy          (busy),
        .expected      (expected),
        .entry         (entry),
        .correct       (correct),
        .wrong         (wrong),
        .attempts_left (attempts_left),
        .disarmed      (disarmed),
        .lockout       (lockout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic, written with integers.
    function automatic int model_ans(input int a, input int b, input int op);
        case (op)
            0:       return (a + b) % 256;
            1:       return (a - b + 256) % 256;
            2:       return (a * b) % 256;
            3:       return (b == 0) ? 0 : a / b;
            4:       return (b == 0) ? 0 : a % b;
            default: return 0;
        endcase
    endfunction

    task automatic do_start(input int a, input int b, input int op);
        calc_t c;
        int    cycles;
        c.a   = a;
        c.b   = b;
        c.op  = op;
        c.ans = 8'(model_ans(a, b, op));
        c.lat = ((op == 3 || op == 4) && b != 0) ? 8 : 1;
        exp_q.push_back(c);
        operand1  = 8'(a);
        operand2  = 8'(b);
        operation = 3'(op);
        start     = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if ({entry, attempts_left, lockout, disarmed} !== {10'd0, 2'd3, 1'b0, 1'b0}) begin
            $display("FAIL start_init %0d,%0d,%0d: entry=%0d att=%0d lock=%b dis=%b want 0,3,0,0",
                     a, b, op, entry, attempts_left, lockout, disarmed);
            bad++;
        end
        cycles = 0;
        while (busy === 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        c = exp_q.pop_front();
        total++;
        if (cycles != c.lat) begin
            $display("FAIL busy_cycles %0d op%0d %0d: got %0d want %0d", c.a, c.op, c.b, cycles, c.lat);
            bad++;
        end
        total++;
        if (expected !== c.ans) begin
            $display("FAIL answer %0d op%0d %0d: got %0d want %0d", c.a, c.op, c.b, expected, c.ans);
            bad++;
        end
    endtask

    task automatic press_digit(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        tick();
        digit_valid = 1'b0;
    endtask

    task automatic press_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // enter, optionally with a digit and/or clear in the same cycle.
    task automatic press_enter(input logic with_digit, input logic with_clear,
                               input logic [3:0] d, input logic exp_c, input logic exp_w);
        enter       = 1'b1;
        digit_valid = with_digit;
        clear       = with_clear;
        digit       = d;
        tick();
        enter       = 1'b0;
        digit_valid = 1'b0;
        clear       = 1'b0;
        total++;
        if ({correct, wrong} !== {exp_c, exp_w}) begin
            $display("FAIL pulse: correct,wrong=%b%b want %b%b", correct, wrong, exp_c, exp_w);
            bad++;
        end
        tick();
        total++;
        if ({correct, wrong} !== 2'b00) begin
            $display("FAIL pulse_width: correct,wrong=%b%b want 00", correct, wrong);
            bad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({busy, expected, entry, correct, wrong, attempts_left, disarmed, lockout} !== 25'd0) begin
            $display("FAIL reset: busy=%b exp=%0d entry=%0d c=%b w=%b att=%0d dis=%b lock=%b want all 0",
                     busy, expected, entry, correct, wrong, attempts_left, disarmed, lockout);
            bad++;
        end
    endtask

    task automatic test_add();
        do_start(7, 5, 0);
        press_digit(4'd1);
        press_digit(4'd2);
        total++;
        if (entry !== 10'd12) begin
            $display("FAIL add_entry: got %0d want 12", entry);
            bad++;
        end
        press_enter(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        total++;
        if ({disarmed, attempts_left} !== {1'b1, 2'd3}) begin
            $display("FAIL add_done: dis=%b att=%0d want 1,3", disarmed, attempts_left);
            bad++;
        end
        // DONE ignores keypad input.
        press_digit(4'd5);
        press_enter(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        total++;
        if ({entry, disarmed} !== {10'd12, 1'b1}) begin
            $display("FAIL done_ignore: entry=%0d dis=%b want 12,1", entry, disarmed);
            bad++;
        end
    endtask

    task automatic test_mul();
        do_start(200, 2, 2);
        press_digit(4'd4);
        press_digit(4'd0);
        press_digit(4'd0);
        total++;
        if (entry !== 10'd400) begin
            $display("FAIL mul_entry: got %0d want 400", entry);
            bad++;
        end
        press_enter(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        total++;
        if ({attempts_left, entry, disarmed} !== {2'd2, 10'd0, 1'b0}) begin
            $display("FAIL mul_wrong: att=%0d entry=%0d dis=%b want 2,0,0", attempts_left, entry, disarmed);
            bad++;
        end
        press_digit(4'd1);
        press_digit(4'd4);
        press_digit(4'd4);
        press_enter(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        total++;
        if ({disarmed, attempts_left} !== {1'b1, 2'd2}) begin
            $display("FAIL mul_right: dis=%b att=%0d want 1,2", disarmed, attempts_left);
            bad++;
        end
    endtask

    task automatic test_div();
        do_start(100, 7, 3);
        do_start(100, 7, 4);
        do_start(9, 0, 3);
        do_start(9, 0, 4);
        do_start(3, 5, 1);
        do_start(12, 3, 7);
        do_start(255, 1, 3);
        do_start(255, 255, 3);
        do_start(254, 255, 4);
        for (int i = 0; i < 6; i++) begin
            do_start(int'($urandom_range(0, 255)), int'($urandom_range(1, 255)),
                     int'($urandom_range(3, 4)));
        end
    endtask

    task automatic test_lockout();
        do_start(1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            press_digit(4'd3);
            press_enter(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
            total++;
            if (attempts_left !== 2'(2 - i)) begin
                $display("FAIL lock_attempts %0d: got %0d want %0d", i, attempts_left, 2 - i);
                bad++;
            end
        end
        total++;
        if (lockout !== 1'b1) begin
            $display("FAIL lockout: got %b want 1", lockout);
            bad++;
        end
        press_digit(4'd2);
        press_enter(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        total++;
        if ({entry, attempts_left, lockout} !== {10'd0, 2'd0, 1'b1}) begin
            $display("FAIL lock_ignore: entry=%0d att=%0d lock=%b want 0,0,1", entry, attempts_left, lockout);
            bad++;
        end
        do_start(4, 4, 2);
    endtask

    task automatic test_entry_edges();
        do_start(10, 5, 0);
        press_enter(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        total++;
        if (attempts_left !== 2'd3) begin
            $display("FAIL empty_enter: att=%0d want 3", attempts_left);
            bad++;
        end
        for (int i = 0; i < 4; i++) press_digit(4'd9);
        total++;
        if (entry !== 10'd999) begin
            $display("FAIL four_nines: got %0d want 999", entry);
            bad++;
        end
        press_clear();
        press_digit(4'd12);
        total++;
        if (entry !== 10'd0) begin
            $display("FAIL bad_digit: got %0d want 0", entry);
            bad++;
        end
        clear       = 1'b1;
        digit_valid = 1'b1;
        digit       = 4'd7;
        tick();
        clear       = 1'b0;
        digit_valid = 1'b0;
        total++;
        if (entry !== 10'd0) begin
            $display("FAIL clear_with_digit: got %0d want 0", entry);
            bad++;
        end
        press_digit(4'd1);
        press_enter(1'b1, 1'b0, 4'd5, 1'b0, 1'b1);
        total++;
        if ({entry, attempts_left} !== {10'd0, 2'd2}) begin
            $display("FAIL enter_with_digit: entry=%0d att=%0d want 0,2", entry, attempts_left);
            bad++;
        end
        press_digit(4'd1);
        press_digit(4'd5);
        press_enter(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        // Restart in the middle of a division; the new problem wins.
        operand1  = 8'd100;
        operand2  = 8'd7;
        operation = 3'b011;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        total++;
        if (busy !== 1'b1) begin
            $display("FAIL mid_div_busy: got %b want 1", busy);
            bad++;
        end
        do_start(5, 5, 0);
        // Restart from ENTRY with a partial entry.
        press_digit(4'd3);
        do_start(6, 6, 2);
    endtask

    task automatic test_reset_mid_div();
        operand1  = 8'd200;
        operand2  = 8'd3;
        operation = 3'b011;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({busy, expected, entry, correct, wrong, attempts_left, disarmed, lockout} !== 25'd0) begin
            $display("FAIL reset_mid_div: busy=%b exp=%0d entry=%0d c=%b w=%b att=%0d dis=%b lock=%b want all 0",
                     busy, expected, entry, correct, wrong, attempts_left, disarmed, lockout);
            bad++;
        end
        press_digit(4'd4);
        press_enter(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        total++;
        if ({busy, entry, expected} !== 19'd0) begin
            $display("FAIL idle_ignore: busy=%b entry=%0d exp=%0d want 0,0,0", busy, entry, expected);
            bad++;
        end
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        operand1    = 8'd0;
        operand2    = 8'd0;
        operation   = 3'd0;
        digit_valid = 1'b0;
        digit       = 4'd0;
        enter       = 1'b0;
        clear       = 1'b0;
        #2;
        test_reset();
        test_add();
        test_mul();
        test_div();
        test_lockout();
        test_entry_edges();
        test_back_to_back();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
